// File: rtl/tate_pairing_host_pkg.sv
// rtl/tate_pairing_host_pkg.sv - shared widths, word counts and state encoding for the tate_pairing host
package tate_pairing_host_pkg;

    localparam int M   = 97;
    localparam int DW  = 32;
    localparam int W2  = 2 * M;
    localparam int W12 = 12 * M;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    localparam int OWORDS = ceil_div(W2, DW);
    localparam int RWORDS = ceil_div(W12, DW);
    localparam int IW     = $clog2(W2);
    localparam int OIW    = $clog2(OWORDS);
    localparam int RIW    = $clog2(RWORDS);

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/tate_pairing_host_serializer.sv
// rtl/tate_pairing_host_serializer.sv - parallel-load F_{3^6m} result, shift out LS word first as a valid/ready stream
module pairing_result_serializer
    import tate_pairing_host_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [W12-1:0] load_data,
    output logic [DW-1:0]  tdata,
    output logic           tvalid,
    input  logic           tready,
    output logic           tlast
);

    logic [W12-1:0] sh_q, sh_d;
    logic [RIW-1:0] idx_q, idx_d;
    logic           vld_q, vld_d;
    logic           is_last;

    assign is_last = (idx_q == RIW'(RWORDS - 1));

    always_comb begin
        sh_d  = sh_q;
        idx_d = idx_q;
        vld_d = vld_q;
        if (load) begin
            sh_d  = load_data;
            idx_d = '0;
            vld_d = 1'b1;
        end else if (vld_q && tready) begin
            // zeros shift in from the top, so the final word is already padded
            sh_d = sh_q >> DW;
            if (is_last) begin
                idx_d = '0;
                vld_d = 1'b0;
            end else begin
                idx_d = idx_q + RIW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            idx_q <= '0;
            vld_q <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            idx_q <= idx_d;
            vld_q <= vld_d;
        end
    end

    assign tdata  = sh_q[DW-1:0];
    assign tvalid = vld_q;
    assign tlast  = vld_q && is_last;

endmodule

// File: rtl/tate_pairing_host.sv
// rtl/tate_pairing_host.sv - loads operands, runs one tate_pairing core and streams its result back out
module tate_pairing_host
    import tate_pairing_host_pkg::*;
#(
    parameter int START_CYC = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_data,
    output logic           out_last,
    output logic           busy,
    output logic [31:0]    cyc_count,
    output logic           pair_reset,
    output logic [W2-1:0]  pair_x1,
    output logic [W2-1:0]  pair_y1,
    output logic [W2-1:0]  pair_x2,
    output logic [W2-1:0]  pair_y2,
    input  logic           pair_done,
    input  logic [W12-1:0] pair_out
);

    state_t         state_q, state_d;
    logic [OIW-1:0] wi_q, wi_d;
    logic [1:0]     opi_q, opi_d;
    logic [7:0]     sc_q, sc_d;
    logic [31:0]    cyc_q, cyc_d;
    logic           pr_q, pr_d;
    logic [W2-1:0]  ops_q [4];
    logic [W2-1:0]  ops_d [4];
    logic           ser_load;
    int             bit_idx;

    always_comb begin
        state_d  = state_q;
        wi_d     = wi_q;
        opi_d    = opi_q;
        sc_d     = sc_q;
        cyc_d    = cyc_q;
        ops_d    = ops_q;
        ser_load = 1'b0;
        bit_idx  = 0;
        case (state_q)
            S_LOAD: if (in_valid) begin
                // bits landing above the operand width are simply dropped
                for (int b = 0; b < DW; b++) begin
                    bit_idx = int'(wi_q) * DW + b;
                    if (bit_idx < W2) ops_d[opi_q][bit_idx[IW-1:0]] = in_data[b];
                end
                if (wi_q == OIW'(OWORDS - 1)) begin
                    wi_d = '0;
                    if (opi_q == 2'd3) begin
                        opi_d   = '0;
                        sc_d    = '0;
                        state_d = S_START;
                    end else begin
                        opi_d = opi_q + 2'd1;
                    end
                end else begin
                    wi_d = wi_q + OIW'(1);
                end
            end
            S_START: begin
                if (sc_q == 8'(START_CYC - 1)) begin
                    cyc_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    sc_d = sc_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (pair_done) begin
                    ser_load = 1'b1;
                    state_d  = S_DRAIN;
                end else if (cyc_q != '1) begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            S_DRAIN: begin
                if (out_valid && out_ready && out_last) begin
                    wi_d    = '0;
                    opi_d   = '0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
        pr_d = (state_d != S_WAIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOAD;
            wi_q    <= '0;
            opi_q   <= '0;
            sc_q    <= '0;
            cyc_q   <= '0;
            pr_q    <= 1'b1;
            for (int i = 0; i < 4; i++) ops_q[i] <= '0;
        end else begin
            state_q <= state_d;
            wi_q    <= wi_d;
            opi_q   <= opi_d;
            sc_q    <= sc_d;
            cyc_q   <= cyc_d;
            pr_q    <= pr_d;
            ops_q   <= ops_d;
        end
    end

    pairing_result_serializer u_ser (
        .clk       (clk),
        .rst_n     (reset),
        .load      (ser_load),
        .load_data (pair_out),
        .tdata     (out_data),
        .tvalid    (out_valid),
        .tready    (out_ready),
        .tlast     (out_last)
    );

    assign in_ready   = (state_q == S_LOAD);
    assign busy       = (state_q != S_LOAD);
    assign cyc_count  = cyc_q;
    assign pair_reset = pr_q;
    assign pair_x1    = ops_q[0];
    assign pair_y1    = ops_q[1];
    assign pair_x2    = ops_q[2];
    assign pair_y2    = ops_q[3];

endmodule

// File: tb/tb_tate_pairing_host.sv
// tb/tb_tate_pairing_host.sv - scoreboard bench for tate_pairing_host with a stub pairing core
module tb_tate_pairing_host;

    localparam int M      = 97;
    localparam int W2     = 2 * M;
    localparam int W12    = 12 * M;
    localparam int RWORDS = 37;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_data;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_data;
    logic            out_last;
    logic            busy;
    logic [31:0]     cyc_count;
    logic            pair_reset;
    logic [W2-1:0]   pair_x1, pair_y1, pair_x2, pair_y2;
    logic            pair_done;
    logic [W12-1:0]  pair_out;

    logic            st_done;
    logic            force_done;
    int              st_cnt;
    int              lat;
    int              checks = 0;
    int              failures = 0;
    logic [31:0]     words [28];
    logic [RWORDS*32-1:0] pw;
    logic [31:0]     exp_q [$];

    always #5 clk = ~clk;

    tate_pairing_host dut (
        .clk        (clk),
        .reset      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .cyc_count  (cyc_count),
        .pair_reset (pair_reset),
        .pair_x1    (pair_x1),
        .pair_y1    (pair_y1),
        .pair_x2    (pair_x2),
        .pair_y2    (pair_y2),
        .pair_done  (pair_done),
        .pair_out   (pair_out)
    );

    // stub core: done rises lat cycles after its reset is released, cleared while held in reset
    always @(posedge clk) begin
        if (pair_reset) begin
            st_cnt  <= 0;
            st_done <= 1'b0;
        end else begin
            st_cnt <= st_cnt + 1;
            if (st_cnt == lat - 1) st_done <= 1'b1;
        end
    end

    assign pair_done = st_done | force_done;
    assign pair_out  = pw[W12-1:0];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = words[k];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic push_expected();
        logic [RWORDS*32-1:0] padded;
        padded = {{(RWORDS*32-W12){1'b0}}, pw[W12-1:0]};
        for (int i = 0; i < RWORDS; i++) exp_q.push_back(padded[i*32 +: 32]);
    endtask

    task automatic drain(input int duty, input int budget);
        int          cnt = 0;
        logic        stalled = 1'b0;
        logic [31:0] prev = '0;
        logic [31:0] e;
        while (exp_q.size() > 0 && cnt < budget) begin
            out_ready = ($urandom_range(99) < duty);
            if (stalled) check("stall_stable", 64'(out_data), 64'(prev));
            stalled = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e));
                    check("out_last", 64'(out_last), 64'(exp_q.size() == 0));
                end else begin
                    stalled = 1'b1;
                    prev    = out_data;
                end
            end
            tick();
            cnt++;
        end
        check("drain_left", 64'(exp_q.size()), 64'(0));
        out_ready = 1'b0;
    endtask

    task automatic do_run(input int lat_i, input int duty, input bit pulse_drain);
        int n;
        lat = lat_i;
        push_expected();
        load_words(28);
        check("in_ready_start", 64'(in_ready), 64'(0));
        check("pr_start1", 64'(pair_reset), 64'(1));
        tick();
        check("pr_start2", 64'(pair_reset), 64'(1));
        tick();
        check("pr_wait", 64'(pair_reset), 64'(0));
        check("busy_wait", 64'(busy), 64'(1));
        check("x1_lo", 64'(pair_x1[31:0]), 64'(words[0]));
        check("x1_top", 64'(pair_x1[W2-1:192]), 64'(words[6][1:0]));
        check("x2_lo", 64'(pair_x2[31:0]), 64'(words[14]));
        check("y2_lo", 64'(pair_y2[31:0]), 64'(words[21]));
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        if (lat_i > 4) begin
            for (int k = 0; k < 3; k++) begin
                check("in_ready_wait", 64'(in_ready), 64'(0));
                tick();
            end
        end
        in_valid = 1'b0;
        if (pulse_drain) begin
            n = 0;
            while (!out_valid && n < 2000) begin
                tick();
                n++;
            end
            check("wait_valid", 64'(out_valid), 64'(1));
            pw = ~pw;
            force_done = 1'b1;
            tick();
            tick();
            force_done = 1'b0;
            check("drain_done_valid", 64'(out_valid), 64'(1));
            if (exp_q.size() > 0) check("drain_done_data", 64'(out_data), 64'(exp_q[0]));
        end
        drain(duty, 3000);
        check("in_ready_end", 64'(in_ready), 64'(1));
        check("busy_end", 64'(busy), 64'(0));
        check("out_valid_end", 64'(out_valid), 64'(0));
        check("cyc_count", 64'(cyc_count), 64'(lat_i));
        check("x1_frozen", 64'(pair_x1[31:0]), 64'(words[0]));
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        force_done = 1'b0;
        lat        = 1000;
        pw         = '0;
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_pair_reset", 64'(pair_reset), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_cyc", 64'(cyc_count), 64'(0));
        check("rst_x1", 64'(pair_x1[63:0]), 64'(0));
        rst_n = 1'b1;
        tick();

        // run 1: ramp operands, byte-ramp result, no backpressure
        for (int k = 0; k < 28; k++) words[k] = 32'(k + 1);
        for (int i = 0; i < RWORDS; i++)
            pw[i*32 +: 32] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        do_run(500, 100, 1'b0);

        // done pulse in LOAD must not start anything
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        tick();
        check("load_done_busy", 64'(busy), 64'(0));
        check("load_done_valid", 64'(out_valid), 64'(0));
        check("load_done_cyc", 64'(cyc_count), 64'(500));

        // run 2: random operands and result, 30% ready, done pulse in DRAIN
        for (int k = 0; k < 28; k++) words[k] = $urandom();
        for (int i = 0; i < RWORDS; i++) pw[i*32 +: 32] = $urandom();
        do_run(123, 30, 1'b1);

        // abort a partial load with a one-cycle reset
        for (int k = 0; k < 28; k++) words[k] = 32'hA00 + 32'(k);
        load_words(10);
        rst_n = 1'b0;
        #1;
        check("abort_pr", 64'(pair_reset), 64'(1));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_x1", 64'(pair_x1[63:0]), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // run 3: fresh load after abort
        for (int k = 0; k < 28; k++) words[k] = $urandom();
        for (int i = 0; i < RWORDS; i++) pw[i*32 +: 32] = $urandom();
        do_run(7, 30, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
